// File: rtl/ct_ifu_predecd_pkg.sv
// Shared types and defaults for the icache predecode array controller.
package ct_ifu_predecd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } predecd_state_e;

    localparam int unsigned STARVE_LIM_DEF = 4;

endpackage

// File: rtl/ct_ifu_icache_predecd_ctrl_if.sv
// Request, response and array-side signals of the predecode array controller.
interface ct_ifu_icache_predecd_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              init_req;
    logic              init_busy;
    logic              refill_req;
    logic [ADDR_W-1:0] refill_addr;
    logic [DATA_W-1:0] refill_data;
    logic              refill_gnt;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rdata_vld;
    logic [DATA_W-1:0] fetch_rdata;
    logic              arr_cen_b;
    logic              arr_wen_b;
    logic [ADDR_W-1:0] arr_index;
    logic [DATA_W-1:0] arr_din;
    logic              arr_clk_en;
    logic [DATA_W-1:0] arr_dout;

    // Master plays both the requesters and the array macro.
    modport master (
        output init_req, refill_req, refill_addr, refill_data, fetch_req, fetch_addr, arr_dout,
        input  init_busy, refill_gnt, fetch_gnt, fetch_rdata_vld, fetch_rdata,
        input  arr_cen_b, arr_wen_b, arr_index, arr_din, arr_clk_en
    );

    modport slave (
        input  init_req, refill_req, refill_addr, refill_data, fetch_req, fetch_addr, arr_dout,
        output init_busy, refill_gnt, fetch_gnt, fetch_rdata_vld, fetch_rdata,
        output arr_cen_b, arr_wen_b, arr_index, arr_din, arr_clk_en
    );

endinterface

// File: rtl/ct_ifu_predecd_arb.sv
// Refill/fetch arbiter: refill wins by default, fetch is forced through after
// STARVE_LIM consecutive refill grants taken while it waited.
module ct_ifu_predecd_arb
    import ct_ifu_predecd_pkg::*;
#(
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic forever_cpuclk,
    input  logic cpurst,
    input  logic arb_en,
    input  logic refill_req,
    input  logic fetch_req,
    output logic refill_gnt,
    output logic fetch_gnt
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             fetch_pri;

    assign fetch_pri  = fetch_req && (starve_cnt_q == CNT_W'(STARVE_LIM));
    assign fetch_gnt  = arb_en && fetch_req && (!refill_req || fetch_pri);
    assign refill_gnt = arb_en && refill_req && !fetch_pri;

    // Counter holds while the array is busy so a pending fetch keeps its credit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!fetch_req || fetch_gnt) begin
            starve_cnt_d = '0;
        end else if (refill_gnt && (starve_cnt_q != CNT_W'(STARVE_LIM))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ct_ifu_icache_predecd_ctrl.sv
// Predecode array controller: invalidate sweep FSM, refill/fetch access muxing
// and the one-cycle read-valid pipe.
module ct_ifu_icache_predecd_ctrl
    import ct_ifu_predecd_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input logic                         forever_cpuclk,
    input logic                         cpurst,
    ct_ifu_icache_predecd_ctrl_if.slave bus
);

    predecd_state_e    state_q, state_d;
    logic              init_pend_q, init_pend_d;
    logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic              rdata_vld_q;
    logic              arb_en;
    logic              refill_gnt;
    logic              fetch_gnt;

    assign bus.init_busy = init_pend_q | (state_q == INIT);
    assign arb_en        = ~bus.init_busy;

    ct_ifu_predecd_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .arb_en         (arb_en),
        .refill_req     (bus.refill_req),
        .fetch_req      (bus.fetch_req),
        .refill_gnt     (refill_gnt),
        .fetch_gnt      (fetch_gnt)
    );

    assign bus.refill_gnt = refill_gnt;
    assign bus.fetch_gnt  = fetch_gnt;

    always_comb begin
        state_d     = state_q;
        init_pend_d = init_pend_q;
        sweep_cnt_d = sweep_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (init_pend_q) begin
                    state_d     = INIT;
                    init_pend_d = 1'b0;
                    sweep_cnt_d = '0;
                end else if (bus.init_req) begin
                    init_pend_d = 1'b1;
                end
            end
            INIT: begin
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                if (&sweep_cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= IDLE;
            init_pend_q <= 1'b1;
            sweep_cnt_q <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pend_q <= init_pend_d;
            sweep_cnt_q <= sweep_cnt_d;
            rdata_vld_q <= fetch_gnt;
        end
    end

    // Grants are already gated off during INIT, so the sweep needs no priority over them.
    always_comb begin
        bus.arr_cen_b = 1'b1;
        bus.arr_wen_b = 1'b1;
        bus.arr_index = '0;
        bus.arr_din   = {DATA_W{1'b0}};
        if (state_q == INIT) begin
            bus.arr_cen_b = 1'b0;
            bus.arr_wen_b = 1'b0;
            bus.arr_index = sweep_cnt_q;
        end else if (refill_gnt) begin
            bus.arr_cen_b = 1'b0;
            bus.arr_wen_b = 1'b0;
            bus.arr_index = bus.refill_addr;
            bus.arr_din   = bus.refill_data;
        end else if (fetch_gnt) begin
            bus.arr_cen_b = 1'b0;
            bus.arr_index = bus.fetch_addr;
        end
    end

    assign bus.arr_clk_en      = ~bus.arr_cen_b;
    assign bus.fetch_rdata_vld = rdata_vld_q;
    assign bus.fetch_rdata     = rdata_vld_q ? bus.arr_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ct_ifu_icache_predecd_ctrl.sv
// Self-checking bench for ct_ifu_icache_predecd_ctrl with a behavioural
// array and a countdown/scoreboard reference model.
module tb_ct_ifu_icache_predecd_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LIM    = 4;
    localparam int          NUM    = 1 << ADDR_W;
    localparam int          VEC_W  = 6 + ADDR_W + DATA_W + 1 + DATA_W;

    logic forever_cpuclk = 1'b0;
    logic cpurst         = 1'b1;
    int   checks         = 0;
    int   errors         = 0;

    ct_ifu_icache_predecd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ct_ifu_icache_predecd_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_LIM (LIM)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .bus            (bus)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural array macro: synchronous write, registered read.
    logic [DATA_W-1:0] arr [NUM];
    always @(posedge forever_cpuclk) begin
        if (!bus.arr_cen_b) begin
            if (!bus.arr_wen_b) arr[bus.arr_index] <= bus.arr_din;
            else                bus.arr_dout       <= arr[bus.arr_index];
        end
    end

    // Reference model. busy_left counts remaining blocked cycles: NUM+1 is the
    // pending cycle, NUM..1 sweep index NUM-busy_left, 0 is free.
    int                busy_left;
    int                starve;
    logic [DATA_W-1:0] mem [NUM];
    logic              vld_m;
    logic [DATA_W-1:0] rdata_m;
    logic              e_busy, e_rgnt, e_fgnt, e_cen, e_wen;
    logic [ADDR_W-1:0] e_idx;
    logic [DATA_W-1:0] e_din;
    logic [VEC_W-1:0]  exp_vec, obs_vec;

    always @* begin
        e_busy = (busy_left > 0);
        e_fgnt = !e_busy && bus.fetch_req && (!bus.refill_req || starve == LIM);
        e_rgnt = !e_busy && bus.refill_req && !e_fgnt;
        e_cen  = 1'b1;
        e_wen  = 1'b1;
        e_idx  = '0;
        e_din  = '0;
        if (e_busy && busy_left <= NUM) begin
            e_cen = 1'b0;
            e_wen = 1'b0;
            e_idx = ADDR_W'(NUM - busy_left);
        end else if (e_rgnt) begin
            e_cen = 1'b0;
            e_wen = 1'b0;
            e_idx = bus.refill_addr;
            e_din = bus.refill_data;
        end else if (e_fgnt) begin
            e_cen = 1'b0;
            e_idx = bus.fetch_addr;
        end
        exp_vec = {e_busy, e_rgnt, e_fgnt, e_cen, e_wen, ~e_cen, e_idx, e_din, vld_m,
                   (vld_m ? rdata_m : {DATA_W{1'b0}})};
    end

    assign obs_vec = {bus.init_busy, bus.refill_gnt, bus.fetch_gnt, bus.arr_cen_b,
                      bus.arr_wen_b, bus.arr_clk_en, bus.arr_index, bus.arr_din,
                      bus.fetch_rdata_vld, bus.fetch_rdata};

    always @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            busy_left <= NUM + 1;
            starve    <= 0;
            vld_m     <= 1'b0;
            rdata_m   <= '0;
        end else begin
            if (busy_left > 0)     busy_left <= busy_left - 1;
            else if (bus.init_req) busy_left <= NUM + 1;
            if (!bus.fetch_req || e_fgnt)  starve <= 0;
            else if (e_rgnt && starve < LIM) starve <= starve + 1;
            if (e_busy && busy_left <= NUM) mem[e_idx] <= '0;
            if (e_rgnt) mem[bus.refill_addr] <= bus.refill_data;
            vld_m   <= e_fgnt;
            rdata_m <= mem[bus.fetch_addr];
        end
    end

    task automatic tick;
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic test_reset;
        cpurst = 1'b1;
        repeat (2) tick();
        @(negedge forever_cpuclk);
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs_vec, exp_vec);
        end
        checks++;
        if (bus.arr_clk_en !== 1'b0 || bus.fetch_rdata !== '0 || bus.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got clk_en=%b rdata=%h busy=%b want 0 0 1",
                     bus.arr_clk_en, bus.fetch_rdata, bus.init_busy);
        end
        tick();
        cpurst = 1'b0;
        for (int c = 0; c <= NUM + 1; c++) begin
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL sweep cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 0 && bus.arr_cen_b !== 1'b1) begin
                errors++;
                $display("FAIL sweep_pend_idle got cen_b=%b want 1", bus.arr_cen_b);
            end
            if (c >= 1 && c <= NUM &&
                (bus.arr_index !== ADDR_W'(c - 1) || bus.arr_wen_b !== 1'b0)) begin
                errors++;
                $display("FAIL sweep_index cyc %0d got %0d want %0d", c, bus.arr_index, c - 1);
            end
            if (c == NUM + 1 && bus.init_busy !== 1'b0) begin
                errors++;
                $display("FAIL sweep_done got busy=%b want 0", bus.init_busy);
            end
            tick();
        end
    endtask

    task automatic test_same_index;
        logic rseen, fseen;
        bus.refill_req  = 1'b1;
        bus.refill_addr = 4'd5;
        bus.refill_data = 32'hA5A5A5A5;
        bus.fetch_req   = 1'b1;
        bus.fetch_addr  = 4'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL same_index cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if ((c == 0 && bus.refill_gnt !== 1'b1) || (c == 1 && bus.fetch_gnt !== 1'b1)) begin
                errors++;
                $display("FAIL same_index_order cyc %0d got r=%b f=%b", c,
                         bus.refill_gnt, bus.fetch_gnt);
            end
            if (c == 2 && (bus.fetch_rdata_vld !== 1'b1 || bus.fetch_rdata !== 32'hA5A5A5A5)) begin
                errors++;
                $display("FAIL same_index_data got vld=%b %h want 1 a5a5a5a5",
                         bus.fetch_rdata_vld, bus.fetch_rdata);
            end
            rseen = bus.refill_gnt;
            fseen = bus.fetch_gnt;
            tick();
            if (rseen) bus.refill_req = 1'b0;
            if (fseen) bus.fetch_req = 1'b0;
        end
    endtask

    task automatic test_starvation;
        int fcount = 0;
        bus.refill_req  = 1'b1;
        bus.refill_addr = 4'd9;
        bus.fetch_req   = 1'b1;
        bus.fetch_addr  = 4'd9;
        for (int c = 0; c < 10; c++) begin
            bus.refill_data = $urandom;
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL starve cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if (bus.fetch_gnt !== ((c % 5) == 4) || bus.refill_gnt !== ((c % 5) != 4)) begin
                errors++;
                $display("FAIL starve_pattern cyc %0d got r=%b f=%b", c,
                         bus.refill_gnt, bus.fetch_gnt);
            end
            if (bus.fetch_gnt === 1'b1) fcount++;
            tick();
        end
        checks++;
        if (fcount != 2) begin
            errors++;
            $display("FAIL starve_count got %0d want 2", fcount);
        end
        bus.refill_req = 1'b0;
        bus.fetch_req  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        for (int c = 0; c < 3; c++) begin
            bus.refill_req  = 1'b1;
            bus.refill_addr = ADDR_W'(c + 1);
            bus.refill_data = w[c];
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b_fill cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            tick();
        end
        bus.refill_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.fetch_req  = (c < 3);
            bus.fetch_addr = ADDR_W'(c + 1);
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b_fetch cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if (c >= 1 && c <= 3 &&
                (bus.fetch_rdata_vld !== 1'b1 || bus.fetch_rdata !== w[c-1])) begin
                errors++;
                $display("FAIL b2b_data cyc %0d got vld=%b %h want 1 %h", c,
                         bus.fetch_rdata_vld, bus.fetch_rdata, w[c-1]);
            end
            tick();
        end
    endtask

    task automatic test_init_req;
        int blocked = 0;
        bit done    = 0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = ADDR_W'($urandom);
        bus.init_req   = 1'b1;
        @(negedge forever_cpuclk);
        checks++;
        if (obs_vec !== exp_vec || bus.fetch_gnt !== 1'b1) begin
            errors++;
            $display("FAIL init_pulse got %h want %h", obs_vec, exp_vec);
        end
        tick();
        bus.init_req = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL init_block cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if (bus.fetch_gnt === 1'b1) done = 1;
            else blocked++;
            tick();
        end
        checks++;
        if (!done || blocked != NUM + 1) begin
            errors++;
            $display("FAIL init_block_len got %0d done=%0d want %0d", blocked, done, NUM + 1);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep;
        bit hit = 0;
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge forever_cpuclk);
            if (bus.init_busy === 1'b1 && bus.arr_wen_b === 1'b0 && bus.arr_index === 4'd7) hit = 1;
            else tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midsweep_reach got no index 7 want index 7");
        end
        cpurst = 1'b1;
        #1;
        checks++;
        if (obs_vec !== exp_vec || bus.arr_cen_b !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_reset got %h want %h", obs_vec, exp_vec);
        end
        tick();
        tick();
        cpurst = 1'b0;
        for (int c = 0; c <= NUM + 1; c++) begin
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL midsweep_restart cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 1 && (bus.arr_index !== 4'd0 || bus.arr_wen_b !== 1'b0)) begin
                errors++;
                $display("FAIL midsweep_first got idx=%0d wen_b=%b want 0 0",
                         bus.arr_index, bus.arr_wen_b);
            end
            tick();
        end
    endtask

    task automatic test_random;
        logic rseen, fseen;
        rseen = 1'b1;
        fseen = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.refill_req || rseen) begin
                bus.refill_req  = ($urandom_range(0, 2) == 0);
                bus.refill_addr = ADDR_W'($urandom_range(0, 3));
                bus.refill_data = $urandom;
            end
            if (!bus.fetch_req || fseen) begin
                bus.fetch_req  = ($urandom_range(0, 1) == 0);
                bus.fetch_addr = ADDR_W'($urandom_range(0, 3));
            end
            bus.init_req = ($urandom_range(0, 99) == 0);
            @(negedge forever_cpuclk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc %0d got %h want %h", c, obs_vec, exp_vec);
            end
            rseen = bus.refill_gnt;
            fseen = bus.fetch_gnt;
            tick();
        end
        bus.refill_req = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.init_req   = 1'b0;
    endtask

    initial begin
        bus.init_req    = 1'b0;
        bus.refill_req  = 1'b0;
        bus.refill_addr = '0;
        bus.refill_data = '0;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        test_reset();
        test_same_index();
        test_starvation();
        test_back_to_back();
        test_init_req();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
